// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states and the stage
// enable/flush bundle layout.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;
  localparam ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// x0-aware match of a producer destination against the two ID source
// registers, gated by the producer's qualifying condition.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             i_en,
  input  logic [REG_W-1:0] i_dst,
  input  logic [REG_W-1:0] i_src1,
  input  logic             i_use1,
  input  logic [REG_W-1:0] i_src2,
  input  logic             i_use2,
  output logic             o_hit
);

  logic w_dst_live;

  assign w_dst_live = i_en && (i_dst != '0);
  assign o_hit      = w_dst_live &&
                      ((i_use1 && (i_src1 == i_dst)) ||
                       (i_use2 && (i_src2 == i_dst)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: arbitrates memory waits, data hazards, ID
// redirects and halt draining into stage enables/flushes.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DM_TIMEOUT = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DRAIN_CYC  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_branch,
  input  logic             id_redirect,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_mem_read,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WD_W = $clog2(DM_TIMEOUT + 1);
  localparam int unsigned DR_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WD_W-1:0]  r_wdog;
  logic [WD_W-1:0]  w_wdog_nxt;
  logic [DR_W-1:0]  r_drain;
  logic [DR_W-1:0]  w_drain_nxt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_wait;
  logic             w_hz_lu;
  logic             w_hz_bex;
  logic             w_hz_bmem;
  logic             w_hz;
  ctrl_t            w_ctrl;

  hazard_cmp u_cmp_loaduse (
    .i_en   (ex_mem_read),
    .i_dst  (ex_rd),
    .i_src1 (id_rs1),
    .i_use1 (id_use_rs1),
    .i_src2 (id_rs2),
    .i_use2 (id_use_rs2),
    .o_hit  (w_hz_lu)
  );

  hazard_cmp u_cmp_br_ex (
    .i_en   (id_is_branch && ex_reg_write),
    .i_dst  (ex_rd),
    .i_src1 (id_rs1),
    .i_use1 (id_use_rs1),
    .i_src2 (id_rs2),
    .i_use2 (id_use_rs2),
    .o_hit  (w_hz_bex)
  );

  hazard_cmp u_cmp_br_mem (
    .i_en   (id_is_branch && mem_mem_read),
    .i_dst  (mem_rd),
    .i_src1 (id_rs1),
    .i_use1 (id_use_rs1),
    .i_src2 (id_rs2),
    .i_use2 (id_use_rs2),
    .o_hit  (w_hz_bmem)
  );

  assign w_hz   = w_hz_lu || w_hz_bex || w_hz_bmem;
  // A frozen pipeline issues no memory traffic, so waits only matter outside HALTED.
  assign w_wait = dmem_req && !dmem_ready && (r_state != ST_HALTED);

  always_comb begin
    w_ctrl = CTRL_RUN;
    if (!reset || (r_state == ST_HALTED)) begin
      w_ctrl = CTRL_IDLE;
    end else if (w_wait) begin
      w_ctrl              = CTRL_IDLE;
      w_ctrl.mem_wb_we    = 1'b1;
      w_ctrl.mem_wb_flush = 1'b1;
    end else if (w_hz) begin
      w_ctrl.pc_we       = 1'b0;
      w_ctrl.if_id_we    = 1'b0;
      w_ctrl.id_ex_flush = 1'b1;
    end else if (r_state == ST_DRAIN) begin
      w_ctrl.pc_we       = 1'b0;
      w_ctrl.if_id_flush = 1'b1;
    end else if (id_redirect) begin
      w_ctrl.if_id_flush = 1'b1;
    end else if (!imem_ready) begin
      w_ctrl.pc_we       = 1'b0;
      w_ctrl.if_id_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    unique case (r_state)
      ST_RUN, ST_DWAIT: begin
        if (w_wait) begin
          w_state_nxt = ST_DWAIT;
        end else if (halt_req) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DR_W'(DRAIN_CYC);
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // halt_req is only re-sampled once the drain count expires.
        if (!w_wait) begin
          if (r_drain <= DR_W'(1)) begin
            w_drain_nxt = '0;
            w_state_nxt = halt_req ? ST_HALTED : ST_RUN;
          end else begin
            w_drain_nxt = r_drain - DR_W'(1);
          end
        end
      end
      ST_HALTED: begin
        if (!halt_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_wdog_nxt = '0;
    if (w_wait) begin
      w_wdog_nxt = (r_wdog == WD_W'(DM_TIMEOUT)) ? r_wdog : r_wdog + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_wdog      <= '0;
      r_drain     <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wdog  <= w_wdog_nxt;
      r_drain <= w_drain_nxt;
      if (w_wait && (w_wdog_nxt == WD_W'(DM_TIMEOUT))) r_err <= 1'b1;
      if (!w_ctrl.pc_we && (r_state != ST_HALTED)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_ctrl.if_id_flush || w_ctrl.id_ex_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign pc_we        = w_ctrl.pc_we;
  assign if_id_we     = w_ctrl.if_id_we;
  assign id_ex_we     = w_ctrl.id_ex_we;
  assign ex_mem_we    = w_ctrl.ex_mem_we;
  assign mem_wb_we    = w_ctrl.mem_wb_we;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign ex_mem_flush = w_ctrl.ex_mem_flush;
  assign mem_wb_flush = w_ctrl.mem_wb_flush;
  assign halted       = (r_state == ST_HALTED);
  assign err_timeout  = r_err;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl: a behavioural model
// queues expected outputs per cycle and a monitor compares them.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DM_TIMEOUT = 16;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned DRAIN_CYC  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd;
  logic             id_use_rs1, id_use_rs2, id_is_branch, id_redirect;
  logic             ex_reg_write, ex_mem_read, mem_mem_read;
  logic             imem_ready, dmem_req, dmem_ready, halt_req;
  logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic             halted, err_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .DM_TIMEOUT (DM_TIMEOUT),
    .CNT_W      (CNT_W),
    .DRAIN_CYC  (DRAIN_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_is_branch (id_is_branch),
    .id_redirect  (id_redirect),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .mem_mem_read (mem_mem_read),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .halt_req     (halt_req),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .id_ex_we     (id_ex_we),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .halted       (halted),
    .err_timeout  (err_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, ex_rd, mem_rd;
    logic       use1, use2, br, redir, ex_wr, ex_ld, mem_ld;
    logic       imem, dreq, drdy, halt;
  } stim_t;

  typedef struct {
    string            tag;
    logic [9:0]       ctl;
    logic             err;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: remaining drain bubbles, frozen flag, consecutive wait cycles.
  int               m_drain_left;
  bit               m_halted;
  int               m_wd;
  bit               m_err;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;

  function automatic void model_reset();
    m_drain_left = 0;
    m_halted     = 1'b0;
    m_wd         = 0;
    m_err        = 1'b0;
    m_stall      = '0;
    m_flush      = '0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.rs1 = '0; s.rs2 = '0; s.ex_rd = '0; s.mem_rd = '0;
    s.use1 = 1'b0; s.use2 = 1'b0; s.br = 1'b0; s.redir = 1'b0;
    s.ex_wr = 1'b0; s.ex_ld = 1'b0; s.mem_ld = 1'b0;
    s.imem = 1'b1; s.dreq = 1'b0; s.drdy = 1'b0; s.halt = 1'b0;
    return s;
  endfunction

  function automatic bit reads_reg(input logic [4:0] rd, input stim_t s);
    return (rd != 5'd0) && ((s.use1 && (s.rs1 == rd)) || (s.use2 && (s.rs2 == rd)));
  endfunction

  task automatic step(input stim_t s, input string tag);
    exp_t     e;
    bit       waitc, hz;
    bit [8:0] c; // pc,if_id,id_ex,ex_mem,mem_wb we | if_id,id_ex,ex_mem,mem_wb flush
    @(negedge clk);
    reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    id_is_branch = s.br; id_redirect = s.redir; ex_rd = s.ex_rd; ex_reg_write = s.ex_wr;
    ex_mem_read = s.ex_ld; mem_rd = s.mem_rd; mem_mem_read = s.mem_ld;
    imem_ready = s.imem; dmem_req = s.dreq; dmem_ready = s.drdy; halt_req = s.halt;
    if (!s.rst) model_reset();
    waitc = s.dreq && !s.drdy && !m_halted;
    hz = (s.ex_ld && reads_reg(s.ex_rd, s)) ||
         (s.br && ((s.ex_wr && reads_reg(s.ex_rd, s)) || (s.mem_ld && reads_reg(s.mem_rd, s))));
    if (!s.rst || m_halted)  c = 9'b00000_0000;
    else if (waitc)          c = 9'b00001_0001;
    else if (hz)             c = 9'b00111_0100;
    else if (m_drain_left>0) c = 9'b01111_1000;
    else if (s.redir)        c = 9'b11111_1000;
    else if (!s.imem)        c = 9'b01111_1000;
    else                     c = 9'b11111_0000;
    e.tag = tag; e.ctl = {c, m_halted && s.rst}; e.err = m_err;
    e.stall = m_stall; e.flush = m_flush;
    sb.push_back(e);
    if (s.rst) begin
      if (!c[8] && !m_halted) m_stall = m_stall + 1'b1;
      if (c[3] || c[2])       m_flush = m_flush + 1'b1;
      if (waitc) begin
        if (m_wd < DM_TIMEOUT) m_wd = m_wd + 1;
        if (m_wd >= DM_TIMEOUT) m_err = 1'b1;
      end else begin
        m_wd = 0;
      end
      if (m_halted) begin
        if (!s.halt) m_halted = 1'b0;
      end else if (m_drain_left > 0) begin
        if (!waitc) begin
          m_drain_left = m_drain_left - 1;
          if (m_drain_left == 0) m_halted = s.halt;
        end
      end else if (!waitc && s.halt) begin
        m_drain_left = DRAIN_CYC;
      end
    end
  endtask

  task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s at %0t: got %0h, expected %0h", tag, what, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "ctl", 64'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush,
                               id_ex_flush, ex_mem_flush, mem_wb_flush, halted}), 64'(e.ctl));
        chk(e.tag, "err_timeout", 64'(err_timeout), 64'(e.err));
        chk(e.tag, "stall_cnt", 64'(stall_cnt), 64'(e.stall));
        chk(e.tag, "flush_cnt", 64'(flush_cnt), 64'(e.flush));
      end
    end
  end

  initial begin
    stim_t s;
    bit    rh;
    reset = 1'b0;
    model_reset();
    s = idle(); s.rst = 1'b0;
    step(s, "reset"); step(s, "reset");
    s = idle(); step(s, "idle"); step(s, "idle");

    s = idle(); s.ex_ld = 1'b1; s.ex_rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b1;
    step(s, "loaduse");
    s = idle(); step(s, "after_lu");
    s = idle(); s.ex_ld = 1'b1; s.ex_wr = 1'b1; s.br = 1'b1; s.use1 = 1'b1;
    step(s, "x0");
    s = idle(); s.br = 1'b1; s.redir = 1'b1; s.ex_wr = 1'b1; s.ex_rd = 5'd3;
    s.rs2 = 5'd3; s.use2 = 1'b1;
    step(s, "br_redir");
    s = idle(); s.br = 1'b1; s.mem_ld = 1'b1; s.mem_rd = 5'd7; s.rs1 = 5'd7; s.use1 = 1'b1;
    step(s, "br_mem");
    s = idle(); s.redir = 1'b1; step(s, "redir");
    s = idle(); s.imem = 1'b0; step(s, "imem_wait");

    s = idle(); s.dreq = 1'b1;
    repeat (3) step(s, "dwait");
    s.drdy = 1'b1; step(s, "dready");
    s = idle(); step(s, "post_dwait");

    s = idle(); s.halt = 1'b1;
    repeat (8) step(s, "halt");
    s.halt = 1'b0; repeat (3) step(s, "unhalt");
    s.halt = 1'b1; step(s, "halt2");
    s.halt = 1'b0; repeat (6) step(s, "drain_drop");

    s = idle(); s.dreq = 1'b1;
    repeat (DM_TIMEOUT + 2) step(s, "wdog");
    s.drdy = 1'b1; step(s, "wdog_done");
    s = idle(); repeat (3) step(s, "post_wdog");

    rh = 1'b0;
    repeat (3000) begin
      s = idle();
      s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
      s.ex_rd = 5'($urandom_range(0, 3)); s.mem_rd = 5'($urandom_range(0, 3));
      s.use1 = 1'($urandom_range(0, 1)); s.use2 = 1'($urandom_range(0, 1));
      s.br = ($urandom_range(0, 99) < 30); s.redir = ($urandom_range(0, 99) < 25);
      s.ex_wr = ($urandom_range(0, 99) < 50); s.ex_ld = ($urandom_range(0, 99) < 25);
      s.mem_ld = ($urandom_range(0, 99) < 25); s.imem = ($urandom_range(0, 99) < 80);
      s.dreq = ($urandom_range(0, 99) < 30); s.drdy = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 29) == 0) rh = ~rh;
      s.halt = rh;
      step(s, "rand");
    end

    s = idle(); s.dreq = 1'b1;
    repeat (5) step(s, "pre_rst");
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    s.rst = 1'b0; step(s, "async_rst");
    s = idle(); repeat (4) step(s, "post_rst");

    for (int i = 0; (i < 20) && (sb.size() > 0); i++) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline. Drives PC write, write-enable and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Arbitrates between these events:
  - load-use and ID-branch data hazards
  - taken-branch/jump redirect in ID
  - instruction- and data-memory wait handshakes
  - an external halt/drain request
- Also keeps a data-memory watchdog and stall/flush performance counters.
- Sits beside the hazard and forward units and replaces their ad-hoc enable wiring.

Parameters:
- DM_TIMEOUT, 16: max cycles dmem_req may wait for dmem_ready before err_timeout sets.
- CNT_W, 32: width of the performance counters.
- DRAIN_CYC, 4: bubble cycles inserted when draining on halt.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2
- id_is_branch  in  1  ID instruction is a conditional branch or jalr (operands compared in ID)
- id_redirect  in  1  ID resolved a taken branch/jump (NPCOp non-sequential)
- ex_rd  in  5  destination register in EX
- ex_reg_write, ex_mem_read  in  1 each  EX instruction writes a register / is a load
- mem_rd  in  5  destination register in MEM
- mem_mem_read  in  1  MEM instruction is a load
- imem_ready  in  1  instruction word valid this cycle
- dmem_req  in  1  MEM stage performing a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- halt_req  in  1  level request to halt fetch
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage register write enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  synchronous bubble insert
- halted  out  1  pipeline drained and frozen
- err_timeout  out  1  sticky dmem watchdog flag
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (reset=0, async):
  - state=RUN, watchdog=0, drain counter=0, err_timeout=0, stall_cnt=0, flush_cnt=0, halted=0.
  - While reset is low, all *_we=0 and all flushes=0.
- States: RUN, DWAIT, DRAIN, HALTED. Control outputs are combinational from state and inputs; state and counters are registered.
- Hazard terms:
  - Register x0 never hazards.
  - Load-use: ex_mem_read and ex_rd equals a used ID source.
  - Branch hazard: id_is_branch and either (ex_reg_write with ex_rd matching) or (mem_mem_read with mem_rd matching).
  - hz = load-use OR branch hazard.
- Priority, highest first:
  1. dmem wait (dmem_req and not dmem_ready): pc/if_id/id_ex/ex_mem we=0; mem_wb_we=1 with mem_wb_flush=1 (bubble, no repeated WB); state moves to or stays in DWAIT.
  2. hz: pc_we=0, if_id_we=0, id_ex_flush=1; EX/MEM and MEM/WB advance. id_redirect is ignored this cycle, because the branch is re-evaluated next cycle.
  3. id_redirect: all we=1, if_id_flush=1 (squash the wrong-path fetch).
  4. imem_ready=0: pc_we=0, if_id_we=1 with if_id_flush=1; downstream advances.
  5. Otherwise all we=1, no flush.
- DWAIT:
  - Watchdog increments each waiting cycle.
  - On reaching DM_TIMEOUT, err_timeout=1 (sticky until reset); the wait continues.
  - dmem_ready=1: the access completes, watchdog clears, state returns to RUN (or DRAIN if halt is pending). Enables that cycle follow rules 2-5.
- halt_req sampled 1 in RUN with no dmem wait:
  - Go to DRAIN and load drain counter = DRAIN_CYC.
  - In DRAIN: pc_we=0, if_id_flush=1; the rest advance subject to rules 1-2. The counter decrements on non-wait cycles.
  - At 0, go to HALTED: all we=0, halted=1.
  - halt_req=0 in HALTED returns to RUN next cycle.
  - halt_req deasserting during DRAIN finishes the drain, then resumes RUN.
- Counters:
  - stall_cnt +1 on any cycle with pc_we=0 outside HALTED.
  - flush_cnt +1 on any cycle where if_id_flush or id_ex_flush is 1.
  - Both wrap modulo 2^CNT_W.

Decomposition:
- Shared package: state encoding (RUN/DWAIT/DRAIN/HALTED) and the bit layout of the enable/flush bundle.
- One sub-module, hazard_cmp: the combinational x0-aware register comparison, instantiated for load-use and branch hazard detection.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_we=0, if_id_we=0, id_ex_flush=1 for 1 cycle; stall_cnt=1, flush_cnt=1.
- Hazard plus redirect: id_rs1=0 with ex_rd=0 -> no stall. Then id_redirect=1 in the same cycle as a branch hazard (ex_reg_write=1, ex_rd=3, id_rs2=3) -> stall wins, if_id_flush=0.
- Data wait: dmem_req=1, dmem_ready=0 for 3 cycles -> pc/if_id/id_ex/ex_mem we=0, mem_wb_flush=1 each cycle; on cycle 4 dmem_ready=1 -> RUN, stall_cnt=3.
- Watchdog: dmem_ready held 0 for DM_TIMEOUT=16 cycles -> err_timeout=1 on cycle 16 and stays 1 after the access completes.
- Halt: halt_req=1 -> 4 cycles of if_id_flush=1, then halted=1 with all we=0; halt_req=0 -> RUN next cycle, all we=1.
- Async reset mid-DWAIT: reset low -> all outputs and counters go to reset values immediately, without waiting for a clock edge; state=RUN after reset rises.
